// File: rtl/heq_phase_ctrl.sv
// heq_phase_ctrl: frame phase sequencer (HIST -> CDF -> DM) and scratch-memory
// port arbiter for the histogram-equalization engine.
// Optional feature macro: HEQ_WATCHDOG_EN adds a per-phase watchdog that aborts
// a stalled phase after WDOG_CYCLES cycles and raises a sticky error flag.
//
//   state    | meaning
//   ---------+-----------------------------------------------
//   S_IDLE   | waiting for start, memory port parked at zero
//   S_HIST   | histogram build stage owns scratch memory
//   S_CDF    | CDF/minimum stage owns scratch memory
//   S_DM     | divide-and-map stage owns scratch memory
//   S_DONE   | one-cycle frame_done slot, start ignored
module heq_phase_ctrl #(
  parameter int WDOG_CYCLES = 65535
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  output logic         busy,
  output logic         frame_done,
  output logic         error,
  output logic [1:0]   phase,
  output logic         hist_enable,
  output logic         cdf_enable,
  output logic         dm_enable,
  input  logic         hist_done,
  input  logic         cdf_done,
  input  logic         dm_done,
  input  logic [31:0]  cdf_min_in,
  output logic [31:0]  cdf_min,
  input  logic [15:0]  hist_sc_mem_rd_addr1,
  input  logic [15:0]  hist_sc_mem_rd_addr2,
  input  logic [15:0]  hist_sc_mem_wt_addr,
  input  logic [127:0] hist_sc_mem_wt_data,
  input  logic         hist_sc_mem_wt_en,
  input  logic [15:0]  cdf_sc_mem_rd_addr1,
  input  logic [15:0]  cdf_sc_mem_rd_addr2,
  input  logic [15:0]  cdf_sc_mem_wt_addr,
  input  logic [127:0] cdf_sc_mem_wt_data,
  input  logic         cdf_sc_mem_wt_en,
  input  logic [15:0]  dm_sc_mem_rd_addr1,
  input  logic [15:0]  dm_sc_mem_rd_addr2,
  input  logic [15:0]  dm_sc_mem_wt_addr,
  input  logic [127:0] dm_sc_mem_wt_data,
  input  logic         dm_sc_mem_wt_en,
  output logic [15:0]  sc_mem_rd_addr1,
  output logic [15:0]  sc_mem_rd_addr2,
  output logic [15:0]  sc_mem_wt_addr,
  output logic [127:0] sc_mem_wt_data,
  output logic         sc_mem_wt_en
);

  typedef enum logic [2:0] {S_IDLE, S_HIST, S_CDF, S_DM, S_DONE} state_t;

  state_t state;
  logic   stage_done;
  logic   wdog_hit;

  assign busy = (state == S_HIST) || (state == S_CDF) || (state == S_DM);

  // Done of the stage that currently owns the frame; other dones are ignored.
  always_comb begin
    stage_done = 1'b0;
    case (phase)
      2'd1:    stage_done = hist_done;
      2'd2:    stage_done = cdf_done;
      2'd3:    stage_done = dm_done;
      default: stage_done = 1'b0;
    endcase
  end

`ifdef HEQ_WATCHDOG_EN
  localparam logic [15:0] WDOG_LAST = 16'(WDOG_CYCLES - 1);

  logic [15:0] wdog_cnt;

  assign wdog_hit = busy && !stage_done && (wdog_cnt == WDOG_LAST);

  // Cycles spent in the current phase; zero on each phase entry.
  always_ff @(posedge clk) begin
    if (reset || !busy || stage_done) wdog_cnt <= 16'd0;
    else                              wdog_cnt <= wdog_cnt + 16'd1;
  end

  // Sticky abort flag, cleared by reset or by the next accepted start.
  always_ff @(posedge clk) begin
    if (reset)                          error <= 1'b0;
    else if (state == S_IDLE && start)  error <= 1'b0;
    else if (wdog_hit)                  error <= 1'b1;
  end
`else
  assign wdog_hit = 1'b0;
  assign error    = 1'b0;
`endif

  // Phase sequencer with registered phase, enable pulses, frame_done and cdf_min.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      phase       <= 2'd0;
      hist_enable <= 1'b0;
      cdf_enable  <= 1'b0;
      dm_enable   <= 1'b0;
      frame_done  <= 1'b0;
      cdf_min     <= 32'd0;
    end else begin
      hist_enable <= 1'b0;
      cdf_enable  <= 1'b0;
      dm_enable   <= 1'b0;
      frame_done  <= 1'b0;
      case (state)
        S_IDLE: if (start) begin
          state       <= S_HIST;
          phase       <= 2'd1;
          hist_enable <= 1'b1;
        end
        S_HIST: if (stage_done) begin
          state      <= S_CDF;
          phase      <= 2'd2;
          cdf_enable <= 1'b1;
        end else if (wdog_hit) begin
          state <= S_IDLE;
          phase <= 2'd0;
        end
        S_CDF: if (stage_done) begin
          state     <= S_DM;
          phase     <= 2'd3;
          dm_enable <= 1'b1;
          cdf_min   <= cdf_min_in;
        end else if (wdog_hit) begin
          state <= S_IDLE;
          phase <= 2'd0;
        end
        S_DM: if (stage_done) begin
          state      <= S_DONE;
          phase      <= 2'd0;
          frame_done <= 1'b1;
        end else if (wdog_hit) begin
          state <= S_IDLE;
          phase <= 2'd0;
        end
        S_DONE:  state <= S_IDLE;
        default: begin
          state <= S_IDLE;
          phase <= 2'd0;
        end
      endcase
    end
  end

  // Scratch-memory port follows the registered owner; parked at zero otherwise.
  always_comb begin
    sc_mem_rd_addr1 = 16'd0;
    sc_mem_rd_addr2 = 16'd0;
    sc_mem_wt_addr  = 16'd0;
    sc_mem_wt_data  = 128'd0;
    sc_mem_wt_en    = 1'b0;
    case (phase)
      2'd1: begin
        sc_mem_rd_addr1 = hist_sc_mem_rd_addr1;
        sc_mem_rd_addr2 = hist_sc_mem_rd_addr2;
        sc_mem_wt_addr  = hist_sc_mem_wt_addr;
        sc_mem_wt_data  = hist_sc_mem_wt_data;
        sc_mem_wt_en    = hist_sc_mem_wt_en;
      end
      2'd2: begin
        sc_mem_rd_addr1 = cdf_sc_mem_rd_addr1;
        sc_mem_rd_addr2 = cdf_sc_mem_rd_addr2;
        sc_mem_wt_addr  = cdf_sc_mem_wt_addr;
        sc_mem_wt_data  = cdf_sc_mem_wt_data;
        sc_mem_wt_en    = cdf_sc_mem_wt_en;
      end
      2'd3: begin
        sc_mem_rd_addr1 = dm_sc_mem_rd_addr1;
        sc_mem_rd_addr2 = dm_sc_mem_rd_addr2;
        sc_mem_wt_addr  = dm_sc_mem_wt_addr;
        sc_mem_wt_data  = dm_sc_mem_wt_data;
        sc_mem_wt_en    = dm_sc_mem_wt_en;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_heq_phase_ctrl.sv
// Bench for heq_phase_ctrl: directed frames checked every cycle against a
// phase-number model, plus literal cycle expectations from the frame plan.
module tb_heq_phase_ctrl;

  localparam int WD = 100;

  logic         clk = 1'b0;
  logic         reset, start;
  logic         busy, frame_done, error;
  logic [1:0]   phase;
  logic         hist_enable, cdf_enable, dm_enable;
  logic         hist_done, cdf_done, dm_done;
  logic [31:0]  cdf_min_in, cdf_min;
  logic [15:0]  h_ra1, h_ra2, h_wa, c_ra1, c_ra2, c_wa, d_ra1, d_ra2, d_wa;
  logic [127:0] h_wd, c_wd, d_wd;
  logic         h_we, c_we, d_we;
  logic [15:0]  sc_mem_rd_addr1, sc_mem_rd_addr2, sc_mem_wt_addr;
  logic [127:0] sc_mem_wt_data;
  logic         sc_mem_wt_en;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  heq_phase_ctrl #(.WDOG_CYCLES(WD)) dut (
    .clk(clk), .reset(reset), .start(start),
    .busy(busy), .frame_done(frame_done), .error(error), .phase(phase),
    .hist_enable(hist_enable), .cdf_enable(cdf_enable), .dm_enable(dm_enable),
    .hist_done(hist_done), .cdf_done(cdf_done), .dm_done(dm_done),
    .cdf_min_in(cdf_min_in), .cdf_min(cdf_min),
    .hist_sc_mem_rd_addr1(h_ra1), .hist_sc_mem_rd_addr2(h_ra2),
    .hist_sc_mem_wt_addr(h_wa), .hist_sc_mem_wt_data(h_wd), .hist_sc_mem_wt_en(h_we),
    .cdf_sc_mem_rd_addr1(c_ra1), .cdf_sc_mem_rd_addr2(c_ra2),
    .cdf_sc_mem_wt_addr(c_wa), .cdf_sc_mem_wt_data(c_wd), .cdf_sc_mem_wt_en(c_we),
    .dm_sc_mem_rd_addr1(d_ra1), .dm_sc_mem_rd_addr2(d_ra2),
    .dm_sc_mem_wt_addr(d_wa), .dm_sc_mem_wt_data(d_wd), .dm_sc_mem_wt_en(d_we),
    .sc_mem_rd_addr1(sc_mem_rd_addr1), .sc_mem_rd_addr2(sc_mem_rd_addr2),
    .sc_mem_wt_addr(sc_mem_wt_addr), .sc_mem_wt_data(sc_mem_wt_data),
    .sc_mem_wt_en(sc_mem_wt_en)
  );

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, got, exp);
    end
  endtask

  // Model: which stage is running (0 = none), how long it has run, and
  // whether we are in the one-cycle gap after a completed frame.
  int          m_p    = 0;
  int          m_age  = 0;
  bit          m_fd   = 0;
  bit          m_err  = 0;
  logic [31:0] m_cmin = 0;

  always @(posedge clk) begin
    bit d;
    if (reset) begin
      m_p = 0; m_age = 0; m_fd = 0; m_err = 0; m_cmin = 0;
    end else if (m_fd) begin
      m_fd = 0;
    end else if (m_p == 0) begin
      if (start) begin m_p = 1; m_age = 0; m_err = 0; end
    end else begin
      d = (m_p == 1) ? hist_done : (m_p == 2) ? cdf_done : dm_done;
      if (d) begin
        if (m_p == 2) m_cmin = cdf_min_in;
        if (m_p == 3) begin m_p = 0; m_fd = 1; end
        else begin m_p = m_p + 1; m_age = 0; end
      end
`ifdef HEQ_WATCHDOG_EN
      else if (m_age == WD - 1) begin m_p = 0; m_err = 1; end
`endif
      else m_age = m_age + 1;
    end
  end

  int hist_en_cyc = -1, cdf_en_cyc = -1, dm_en_cyc = -1, fd_cyc = -1, busy_cnt = 0;

  // Every-cycle comparison against the model, sampled on the falling edge.
  always @(negedge clk) begin
    logic [15:0]  e_ra1, e_ra2, e_wa;
    logic [127:0] e_wd;
    logic         e_we;
    if (cyc >= 1) begin
      e_ra1 = 0; e_ra2 = 0; e_wa = 0; e_wd = 0; e_we = 0;
      if (m_p == 1) begin e_ra1 = h_ra1; e_ra2 = h_ra2; e_wa = h_wa; e_wd = h_wd; e_we = h_we; end
      if (m_p == 2) begin e_ra1 = c_ra1; e_ra2 = c_ra2; e_wa = c_wa; e_wd = c_wd; e_we = c_we; end
      if (m_p == 3) begin e_ra1 = d_ra1; e_ra2 = d_ra2; e_wa = d_wa; e_wd = d_wd; e_we = d_we; end
      check("phase", phase, m_p[1:0]);
      check("busy", busy, m_p != 0);
      check("hist_enable", hist_enable, m_p == 1 && m_age == 0);
      check("cdf_enable", cdf_enable, m_p == 2 && m_age == 0);
      check("dm_enable", dm_enable, m_p == 3 && m_age == 0);
      check("frame_done", frame_done, m_fd);
      check("error", error, m_err);
      check("cdf_min", cdf_min, m_cmin);
      check("sc_rd_addr1", sc_mem_rd_addr1, e_ra1);
      check("sc_rd_addr2", sc_mem_rd_addr2, e_ra2);
      check("sc_wt_addr", sc_mem_wt_addr, e_wa);
      check("sc_wt_data", sc_mem_wt_data, e_wd);
      check("sc_wt_en", sc_mem_wt_en, e_we);
      if (hist_enable) hist_en_cyc = cyc;
      if (cdf_enable)  cdf_en_cyc  = cyc;
      if (dm_enable)   dm_en_cyc   = cyc;
      if (frame_done)  fd_cyc      = cyc;
      if (busy && cyc < 300) busy_cnt++;
    end
  end

  task automatic goto(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    reset = 1; start = 0; hist_done = 0; cdf_done = 0; dm_done = 0; cdf_min_in = 32'd99;
    h_ra1 = 16'h0011; h_ra2 = 16'h0012; h_wa = 16'h0010; h_wd = {4{32'hA1A1_0001}}; h_we = 1;
    c_ra1 = 16'h0021; c_ra2 = 16'h0022; c_wa = 16'h0020; c_wd = {4{32'hB2B2_0002}}; c_we = 1;
    d_ra1 = 16'h0031; d_ra2 = 16'h0032; d_wa = 16'h0030; d_wd = {4{32'hC3C3_0003}}; d_we = 1;

    goto(2);
    check("reset phase", phase, 2'd0);
    check("reset wt_en blocked", sc_mem_wt_en, 1'b0);
    check("reset wt_addr", sc_mem_wt_addr, 16'h0000);
    goto(4); reset = 0;

    // Normal frame with stray handshakes and a stray start.
    goto(10); start = 1;
    goto(11); start = 0;
    check("frame1 hist_enable@11", hist_enable, 1'b1);
    check("frame1 busy@11", busy, 1'b1);
    goto(12);
    check("frame1 hist_enable@12", hist_enable, 1'b0);
    goto(20); cdf_done = 1; dm_done = 1;
    goto(21); cdf_done = 0; dm_done = 0;
    goto(25);
    check("stray dones phase", phase, 2'd1);
    goto(30);
    check("hist owner wt_addr", sc_mem_wt_addr, 16'h0010);
    check("hist owner wt_data", sc_mem_wt_data, {4{32'hA1A1_0001}});
    goto(50); hist_done = 1;
    goto(51); hist_done = 0;
    goto(60); start = 1;
    goto(61); start = 0;
    goto(70);
    check("cdf owner wt_addr", sc_mem_wt_addr, 16'h0020);
    goto(85); cdf_min_in = 32'd18;
    goto(90); cdf_done = 1;
    goto(91); cdf_done = 0; cdf_min_in = 32'd1234;
    check("cdf_min@91", cdf_min, 32'd18);
    goto(150);
    check("dm owner wt_addr", sc_mem_wt_addr, 16'h0030);
    check("dm owner rd_addr1", sc_mem_rd_addr1, 16'h0031);
    goto(200); dm_done = 1;
    goto(201); dm_done = 0;
    check("frame_done@201", frame_done, 1'b1);
    goto(210);
    check("no second frame phase", phase, 2'd0);
    check("idle wt_en blocked", sc_mem_wt_en, 1'b0);
    check("hist_enable cycle", hist_en_cyc, 11);
    check("cdf_enable cycle", cdf_en_cyc, 51);
    check("dm_enable cycle", dm_en_cyc, 91);
    check("frame_done cycle", fd_cyc, 201);
    check("busy cycles 11..200", busy_cnt, 190);

    // Reset mid-DM; hist_done held across the HIST entry cycle.
    goto(300); start = 1; hist_done = 1;
    goto(301); start = 0;
    goto(306); hist_done = 0;
    check("held done advances one phase", phase, 2'd2);
    goto(315); cdf_min_in = 32'd77;
    goto(320); cdf_done = 1;
    goto(321); cdf_done = 0;
    goto(350); reset = 1;
    goto(351); reset = 0;
    check("mid reset phase", phase, 2'd0);
    check("mid reset dm_enable", dm_enable, 1'b0);
    check("mid reset cdf_min", cdf_min, 32'd0);
    check("mid reset wt_en", sc_mem_wt_en, 1'b0);
    goto(360); start = 1;
    goto(361); start = 0;
    goto(365); hist_done = 1;
    goto(366); hist_done = 0; cdf_min_in = 32'd5;
    goto(370); cdf_done = 1;
    goto(371); cdf_done = 0;
    goto(380); dm_done = 1;
    goto(381); dm_done = 0;
    check("post-reset frame_done", frame_done, 1'b1);
    check("post-reset cdf_min", cdf_min, 32'd5);

    // Back-to-back frames with start held high.
    goto(400); start = 1;
    goto(410); hist_done = 1;
    goto(411); hist_done = 0;
    goto(420); cdf_done = 1;
    goto(421); cdf_done = 0;
    goto(430); dm_done = 1;
    goto(431); dm_done = 0;
    goto(434);
    check("b2b first frame_done cycle", fd_cyc, 431);
    check("b2b second hist_enable 2 cycles after frame_done", hist_en_cyc, 433);
    goto(440); hist_done = 1;
    goto(441); hist_done = 0;
    goto(450); cdf_done = 1;
    goto(451); cdf_done = 0;
    goto(452); start = 0;
    goto(460); dm_done = 1;
    goto(461); dm_done = 0;
    goto(470);
    check("b2b ends idle", phase, 2'd0);

`ifdef HEQ_WATCHDOG_EN
    // Watchdog: CDF never finishes.
    goto(500); start = 1;
    goto(501); start = 0;
    goto(505); hist_done = 1;
    goto(506); hist_done = 0;
    goto(605);
    check("wdog still waiting", phase, 2'd2);
    goto(606);
    check("wdog error", error, 1'b1);
    check("wdog phase", phase, 2'd0);
    check("wdog no frame_done", frame_done, 1'b0);
    goto(620); start = 1;
    goto(621); start = 0;
    check("wdog error cleared", error, 1'b0);
    goto(625); hist_done = 1;
    goto(626); hist_done = 0;
    goto(630); cdf_done = 1;
    goto(631); cdf_done = 0;
    goto(640); dm_done = 1;
    goto(641); dm_done = 0;
    check("wdog recovered frame_done", frame_done, 1'b1);
`endif

    goto(660);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
